io_port_ctrl: RTL and testbench

- Character I/O front end for the 18-bit accumulator processor.
- Upstream of the datapath's INPR path: captures device input into a holding register and raises flg_i; the processor clears flg_i with inpr_read.
- Downstream of the OUTR path: buffers words written with outr_write and serialises them to an external device over a valid/ready handshake.
- Generates the interrupt request from flg_i/flg_o, gated by glob_ie, en_i and en_o.

---
 rtl/io_port_ctrl_pkg.sv | 12 +
 rtl/io_out_fifo.sv | 56 +++++
 rtl/io_port_ctrl.sv | 138 +++++++++++++
 tb/tb_io_port_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/io_port_ctrl_pkg.sv
// Shared types and default widths for the character I/O port controller.
package io_port_ctrl_pkg;

  localparam int WORD_W = 18;
  localparam int CHAR_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous FIFO buffering outgoing characters between OUTR writes and the device.
module io_out_fifo
  import io_port_ctrl_pkg::*;
#(
  parameter int W     = CHAR_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// Character I/O front end: input holding register, buffered output serialiser, interrupt request.
// Define IO_PORT_IRQ_EN to generate irq from the flags; otherwise irq is tied low.
module io_port_ctrl
  import io_port_ctrl_pkg::*;
#(
  parameter int DATA_W    = WORD_W,
  parameter int DEV_W     = CHAR_W,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inpr_read,
  output logic [DATA_W-1:0] inpr_data,
  output logic              flg_i,
  input  logic              outr_write,
  input  logic [DATA_W-1:0] outr_data,
  output logic              flg_o,
  input  logic              glob_ie,
  input  logic              en_i,
  input  logic              en_o,
  output logic              irq,
  input  logic              dev_in_valid,
  input  logic [DEV_W-1:0]  dev_in_data,
  output logic              dev_in_ready,
  output logic              dev_out_valid,
  output logic [DEV_W-1:0]  dev_out_data,
  input  logic              dev_out_ready
);

  logic [DATA_W-1:0] inpr_q;
  logic              flg_i_q;
  out_state_e        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DEV_W-1:0]  out_data_q, out_data_d;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [DEV_W-1:0]  fifo_rdata;
  logic [$clog2(OUT_DEPTH):0] unused_fifo_count;
  logic              unused_outr_bits;

  assign unused_outr_bits = ^outr_data;

  assign inpr_data     = inpr_q;
  assign flg_i         = flg_i_q;
  assign dev_in_ready  = ~flg_i_q;
  assign flg_o         = ~fifo_full;
  assign dev_out_valid = out_valid_q;
  assign dev_out_data  = out_data_q;

  // Capture requires flg_i low and clearing requires it high, so they never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inpr_q  <= '0;
      flg_i_q <= 1'b0;
    end else if (dev_in_valid && !flg_i_q) begin
      inpr_q  <= DATA_W'(dev_in_data);
      flg_i_q <= 1'b1;
    end else if (inpr_read && flg_i_q) begin
      flg_i_q <= 1'b0;
    end
  end

  io_out_fifo #(
    .W     (DEV_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (outr_write),
    .pop_i   (fifo_pop),
    .wdata_i (outr_data[DEV_W-1:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // The output register acts as one extra buffer slot; a handshake refills it on the same edge.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          out_data_d  = fifo_rdata;
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (dev_out_ready) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            out_data_d = fifo_rdata;
          end else begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

`ifdef IO_PORT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq_q <= 1'b0;
    else      irq_q <= glob_ie & ((en_i & flg_i_q) | (en_o & ~fifo_full));
  end

  assign irq = irq_q;
`else
  logic unused_irq_inputs;

  assign unused_irq_inputs = glob_ie ^ en_i ^ en_o;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboard bench for io_port_ctrl: queue-level reference model, randomized and directed traffic.
module tb_io_port_ctrl;

  localparam int DATA_W    = 18;
  localparam int DEV_W     = 8;
  localparam int OUT_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              inpr_read = 1'b0;
  logic [DATA_W-1:0] inpr_data;
  logic              flg_i;
  logic              outr_write = 1'b0;
  logic [DATA_W-1:0] outr_data = '0;
  logic              flg_o;
  logic              glob_ie = 1'b0;
  logic              en_i = 1'b0;
  logic              en_o = 1'b0;
  logic              irq;
  logic              dev_in_valid = 1'b0;
  logic [DEV_W-1:0]  dev_in_data = '0;
  logic              dev_in_ready;
  logic              dev_out_valid;
  logic [DEV_W-1:0]  dev_out_data;
  logic              dev_out_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [DEV_W-1:0]  expQ[$];
  int                mOcc;
  bit                mHold, mFlgI, mIrq;
  logic [DATA_W-1:0] mInpr;

  io_port_ctrl #(
    .DATA_W    (DATA_W),
    .DEV_W     (DEV_W),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inpr_read     (inpr_read),
    .inpr_data     (inpr_data),
    .flg_i         (flg_i),
    .outr_write    (outr_write),
    .outr_data     (outr_data),
    .flg_o         (flg_o),
    .glob_ie       (glob_ie),
    .en_i          (en_i),
    .en_o          (en_o),
    .irq           (irq),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake consumes the oldest accepted character.
  always @(negedge clk) begin
    if (rst && dev_out_valid && dev_out_ready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL dev_out_data: got %0h expected nothing queued", dev_out_data);
      end else begin
        checkOutput("dev_out_data", dev_out_data, expQ.pop_front());
      end
    end
  end

  task automatic resetModel();
    mOcc  = 0;
    mHold = 0;
    mFlgI = 0;
    mIrq  = 0;
    mInpr = '0;
    expQ.delete();
  endtask

  // One cycle: drive at posedge+1, check at negedge, then advance the model over the coming edge.
  task automatic applyStimulus(input bit w, input logic [DATA_W-1:0] wd, input bit r,
                               input bit v, input logic [DEV_W-1:0] vd, input bit rd,
                               input bit ge, input bit ei, input bit eo);
    bit acc, pop, nextIrq;
    outr_write    = w;
    outr_data     = wd;
    dev_out_ready = r;
    dev_in_valid  = v;
    dev_in_data   = vd;
    inpr_read     = rd;
    glob_ie       = ge;
    en_i          = ei;
    en_o          = eo;
    @(negedge clk);
    checkOutput("flg_o", flg_o, (mOcc != OUT_DEPTH));
    checkOutput("dev_out_valid", dev_out_valid, mHold);
    checkOutput("flg_i", flg_i, mFlgI);
    checkOutput("dev_in_ready", dev_in_ready, !mFlgI);
    checkOutput("inpr_data", inpr_data, mInpr);
    checkOutput("irq", irq, mIrq);
    acc     = w && (mOcc < OUT_DEPTH);
    pop     = (mOcc > 0) && (!mHold || r);
    nextIrq = ge && ((ei && mFlgI) || (eo && (mOcc != OUT_DEPTH)));
    if (acc) expQ.push_back(wd[DEV_W-1:0]);
    if (pop) mHold = 1;
    else if (mHold && r) mHold = 0;
    mOcc = mOcc + int'(acc) - int'(pop);
    if (v && !mFlgI) begin
      mFlgI = 1;
      mInpr = DATA_W'(vd);
    end else if (rd && mFlgI) begin
      mFlgI = 0;
    end
`ifdef IO_PORT_IRQ_EN
    mIrq = nextIrq;
`else
    mIrq = 0;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit r, input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, r, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int budget;
    budget = 60;
    while ((expQ.size() != 0 || mHold) && budget > 0) begin
      applyStimulus(0, '0, 1, 0, '0, 0, 0, 0, 0);
      budget--;
    end
    checkOutput("drained", expQ.size(), 0);
  endtask

  initial begin
    resetModel();
    rst = 1'b0;
    #12;
    checkOutput("reset_valid", dev_out_valid, 0);
    checkOutput("reset_data", dev_out_data, 0);
    checkOutput("reset_flg_i", flg_i, 0);
    checkOutput("reset_inpr", inpr_data, 0);
    checkOutput("reset_irq", irq, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(0, 2);

    $display("[TB] input path");
    applyStimulus(0, '0, 0, 1, 8'h41, 0, 1, 1, 0);
    checkOutput("capture_41", inpr_data, 18'h00041);
    applyStimulus(0, '0, 0, 1, 8'h42, 0, 1, 1, 0);
    applyStimulus(0, '0, 0, 1, 8'h42, 0, 1, 1, 0);
    checkOutput("held_41", inpr_data, 18'h00041);
    applyStimulus(0, '0, 0, 1, 8'h42, 1, 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 8'h42, 0, 0, 1, 0);
    checkOutput("capture_42", inpr_data, 18'h00042);
    applyStimulus(0, '0, 0, 0, '0, 1, 0, 0, 0);
    idle(0, 2);

    $display("[TB] output burst");
    applyStimulus(1, 18'h3FF55, 1, 0, '0, 0, 0, 0, 0);
    applyStimulus(1, 18'h00066, 1, 0, '0, 0, 0, 0, 0);
    idle(1, 4);
    checkOutput("burst_done", expQ.size(), 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 6; i++)
      applyStimulus(1, DATA_W'($urandom), 0, 0, '0, 0, 1, 0, 1);
    checkOutput("full_flg_o", flg_o, 0);
    checkOutput("accepted_5", expQ.size(), 5);
    drain();

    $display("[TB] reset during transfer");
    applyStimulus(1, 18'h000A5, 0, 0, '0, 0, 0, 0, 0);
    applyStimulus(1, 18'h0005A, 0, 0, '0, 0, 0, 0, 0);
    idle(0, 1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_valid_drop", dev_out_valid, 0);
    checkOutput("async_flg_o", flg_o, 1);
    resetModel();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(0, 3);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), DATA_W'($urandom), ($urandom % 4) != 0,
                    $urandom_range(0, 1), DEV_W'($urandom), ($urandom % 3) == 0,
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
